// File: rtl/addr_mode_seq.sv
// Addressing-mode sequencer for the 6502 core: walks operand, index, fix-up, indirect and
// load/store/RMW bus cycles. Define NMOS_IND_WRAP_EN to reproduce the NMOS indirect page-wrap.
module addr_mode_seq #(
  parameter int                DATA_W  = 8,
  parameter int                ADDR_W  = 16,
  parameter logic [DATA_W-1:0] ZP_PAGE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        mode,
  input  logic              rmw,
  input  logic              store,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] x_idx,
  input  logic [DATA_W-1:0] y_idx,
  input  logic [DATA_W-1:0] wr_value,
  input  logic [DATA_W-1:0] modify_value,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] address,
  output logic              rd_en,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ea,
  output logic [DATA_W-1:0] operand,
  output logic [1:0]        nbytes
);

  if (ADDR_W != 2 * DATA_W) begin : g_bad_width
    $error("addr_mode_seq: ADDR_W must equal 2*DATA_W");
  end

  localparam logic [2:0] M_IMM = 3'd0, M_ZP = 3'd1, M_ZPX = 3'd2, M_ZPY = 3'd3;
  localparam logic [2:0] M_ABS = 3'd4, M_ABSX = 3'd5, M_ABSY = 3'd6, M_IND = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_OP_LO, S_OP_HI, S_FIX, S_IND_LO, S_IND_HI, S_ACCESS, S_MODIFY, S_WRITE
  } state_t;

  // Handshake: start is taken only while busy is low (including the done cycle);
  // done pulses for one cycle after the last bus cycle, with ea/operand/nbytes valid.
  state_t              state_q, state_d;
  logic [2:0]          mode_q, mode_d;
  logic                rmw_q, rmw_d, store_q, store_d, carry_q, carry_d;
  logic [DATA_W-1:0]   idx_q, idx_d, wr_value_q, wr_value_d;
  logic [DATA_W-1:0]   lo_q, lo_d, hi_q, hi_d, tl_q, tl_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   address_d, ea_d;
  logic                rd_en_d, wr_en_d, busy_d, done_d;
  logic [DATA_W-1:0]   wr_data_d, operand_d;
  logic [1:0]          nbytes_d;
  logic                zp_mode, mem_mode, idx_carry;
  logic [DATA_W-1:0]   idx_sum;

  assign zp_mode  = (mode_q == M_ZP) || (mode_q == M_ZPX) || (mode_q == M_ZPY);
  assign mem_mode = (mode != M_IMM) && (mode != M_IND);
  assign {idx_carry, idx_sum} = {1'b0, lo_q} + {1'b0, idx_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_OP_LO;
      S_OP_LO:  if (mode_q == M_IMM) state_d = S_IDLE;
                else if (zp_mode)  state_d = S_ACCESS;
                else               state_d = S_OP_HI;
      S_OP_HI:  if (mode_q == M_IND)      state_d = S_IND_LO;
                else if (mode_q == M_ABS) state_d = S_ACCESS;
                else state_d = (idx_carry || rmw_q || store_q) ? S_FIX : S_ACCESS;
      S_FIX:    state_d = S_ACCESS;
      S_IND_LO: state_d = S_IND_HI;
      S_IND_HI: state_d = S_IDLE;
      S_ACCESS: state_d = rmw_q ? S_MODIFY : S_IDLE;
      S_MODIFY: state_d = S_WRITE;
      S_WRITE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    address_d = address;  rd_en_d = rd_en;  wr_en_d = wr_en;  wr_data_d = wr_data;
    busy_d = busy;  done_d = 1'b0;  ea_d = ea;  operand_d = operand;  nbytes_d = nbytes;
    mode_d = mode_q;  idx_d = idx_q;  rmw_d = rmw_q;  store_d = store_q;
    wr_value_d = wr_value_q;  pc_d = pc_q;  lo_d = lo_q;  hi_d = hi_q;  tl_d = tl_q;
    carry_d = carry_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        address_d  = pc;
        rd_en_d    = 1'b1;
        busy_d     = 1'b1;
        mode_d     = mode;
        idx_d      = ((mode == M_ZPY) || (mode == M_ABSY)) ? y_idx :
                     ((mode == M_ZPX) || (mode == M_ABSX)) ? x_idx : '0;
        rmw_d      = rmw && mem_mode;
        store_d    = store && !rmw && mem_mode;
        wr_value_d = wr_value;
        pc_d       = pc;
      end
      S_OP_LO: begin
        lo_d = rd_data;
        if (mode_q == M_IMM) begin
          operand_d = rd_data;
          ea_d      = pc_q;
        end else if (zp_mode) begin
          address_d = {ZP_PAGE, DATA_W'(rd_data + idx_q)};
        end else begin
          address_d = pc_q + ADDR_W'(1);
        end
      end
      S_OP_HI: begin
        hi_d    = rd_data;
        carry_d = idx_carry;
        if ((mode_q == M_ABSX) || (mode_q == M_ABSY)) address_d = {rd_data, idx_sum};
        else                                          address_d = {rd_data, lo_q};
      end
      S_FIX:    address_d = {DATA_W'(hi_q + DATA_W'(carry_q)), address[DATA_W-1:0]};
      S_IND_LO: begin
        tl_d = rd_data;
`ifdef NMOS_IND_WRAP_EN
        address_d = {hi_q, DATA_W'(lo_q + DATA_W'(1))};
`else
        address_d = {hi_q, lo_q} + ADDR_W'(1);
`endif
      end
      S_IND_HI: ea_d = {rd_data, tl_q};
      S_ACCESS: begin
        ea_d = address;
        if (!store_q) operand_d = rd_data;
        if (rmw_q) begin
          // Dummy write of the unmodified value, as the NMOS part does.
          rd_en_d   = 1'b0;
          wr_en_d   = 1'b1;
          wr_data_d = rd_data;
        end
      end
      S_MODIFY: begin
        wr_data_d = modify_value;
        wr_en_d   = 1'b1;
      end
      S_WRITE:  ;
      default:  ;
    endcase
    if ((state_d == S_ACCESS) && (state_q != S_ACCESS)) begin
      if (store_q) begin
        wr_en_d   = 1'b1;
        rd_en_d   = 1'b0;
        wr_data_d = wr_value_q;
      end else begin
        rd_en_d = 1'b1;
      end
    end
    if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
      busy_d   = 1'b0;
      rd_en_d  = 1'b0;
      wr_en_d  = 1'b0;
      done_d   = 1'b1;
      nbytes_d = ((mode_q == M_IMM) || zp_mode) ? 2'd1 : 2'd2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address <= '0;  rd_en <= 1'b0;  wr_en <= 1'b0;  wr_data <= '0;
      busy <= 1'b0;  done <= 1'b0;  ea <= '0;  operand <= '0;  nbytes <= '0;
      mode_q <= '0;  idx_q <= '0;  rmw_q <= 1'b0;  store_q <= 1'b0;  carry_q <= 1'b0;
      wr_value_q <= '0;  pc_q <= '0;  lo_q <= '0;  hi_q <= '0;  tl_q <= '0;
    end else begin
      address <= address_d;  rd_en <= rd_en_d;  wr_en <= wr_en_d;  wr_data <= wr_data_d;
      busy <= busy_d;  done <= done_d;  ea <= ea_d;  operand <= operand_d;  nbytes <= nbytes_d;
      mode_q <= mode_d;  idx_q <= idx_d;  rmw_q <= rmw_d;  store_q <= store_d;  carry_q <= carry_d;
      wr_value_q <= wr_value_d;  pc_q <= pc_d;  lo_q <= lo_d;  hi_q <= hi_d;  tl_q <= tl_d;
    end
  end

endmodule

// File: tb/tb_addr_mode_seq.sv
// Bench for addr_mode_seq: directed vector table, reset-abort sequence and random
// transactions checked against a bus-level reference model with a byte-array memory.
module tb_addr_mode_seq;

  localparam logic [2:0] M_IMM = 3'd0, M_ZP = 3'd1, M_ZPX = 3'd2, M_ZPY = 3'd3;
  localparam logic [2:0] M_ABS = 3'd4, M_ABSX = 3'd5, M_ABSY = 3'd6, M_IND = 3'd7;

  logic        clk, reset, start, rmw, store;
  logic [2:0]  mode;
  logic [15:0] pc, address, ea;
  logic [7:0]  x_idx, y_idx, wr_value, modify_value, rd_data, wr_data, operand;
  logic        rd_en, wr_en, busy, done;
  logic [1:0]  nbytes;

  logic [7:0]  mem [0:65535];
  assign rd_data = mem[address];

  addr_mode_seq dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .rmw(rmw), .store(store),
    .pc(pc), .x_idx(x_idx), .y_idx(y_idx), .wr_value(wr_value),
    .modify_value(modify_value), .rd_data(rd_data), .address(address), .rd_en(rd_en),
    .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .done(done), .ea(ea),
    .operand(operand), .nbytes(nbytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected bus operations: {write, address, write data (0 for reads)}.
  logic [24:0] exp_q[$];
  logic [15:0] m_ea;
  logic [7:0]  m_op, last_operand;
  logic [1:0]  m_nb;
  int          m_cyc;

  typedef struct {
    logic [2:0]  mode;
    logic        rmw, store;
    logic [15:0] pc;
    logic [7:0]  x, y, wv, mv;
    logic [15:0] ea;
    logic [7:0]  operand;
    logic [1:0]  nb;
    int          cyc;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_access(input logic [15:0] a, input logic r, input logic s,
                              input logic [7:0] wv, input logic [7:0] mv);
    m_ea = a;
    if (r) begin
      exp_q.push_back({1'b0, a, 8'h00});
      exp_q.push_back({1'b1, a, mem[a]});
      exp_q.push_back({1'b1, a, mv});
      m_op = mem[a];
    end else if (s) begin
      exp_q.push_back({1'b1, a, wv});
    end else begin
      exp_q.push_back({1'b0, a, 8'h00});
      m_op = mem[a];
    end
  endtask

  task automatic model_txn(input logic [2:0] m, input logic r, input logic s,
                           input logic [15:0] p, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] wv, input logic [7:0] mv);
    logic       mem_op, er, es;
    logic [7:0] idx, lo, hi, zl;
    logic [15:0] a, ptr, ptr2;
    exp_q.delete();
    mem_op = (m != M_IMM) && (m != M_IND);
    er = r && mem_op;
    es = s && !r && mem_op;
    idx = (m == M_ZPY || m == M_ABSY) ? y : (m == M_ZPX || m == M_ABSX) ? x : 8'h00;
    m_op = last_operand;
    lo = mem[p];
    exp_q.push_back({1'b0, p, 8'h00});
    if (m == M_IMM) begin
      m_ea = p; m_op = lo; m_nb = 2'd1;
    end else if (m == M_ZP || m == M_ZPX || m == M_ZPY) begin
      zl = lo + idx;
      model_access({8'h00, zl}, er, es, wv, mv);
      m_nb = 2'd1;
    end else begin
      hi = mem[16'(p + 16'd1)];
      exp_q.push_back({1'b0, 16'(p + 16'd1), 8'h00});
      m_nb = 2'd2;
      if (m == M_IND) begin
        ptr = {hi, lo};
`ifdef NMOS_IND_WRAP_EN
        ptr2 = {hi, 8'(lo + 8'd1)};
`else
        ptr2 = ptr + 16'd1;
`endif
        exp_q.push_back({1'b0, ptr, 8'h00});
        exp_q.push_back({1'b0, ptr2, 8'h00});
        m_ea = {mem[ptr2], mem[ptr]};
      end else begin
        a = {hi, lo} + {8'h00, idx};
        if (m != M_ABS && (a[15:8] != hi || er || es))
          exp_q.push_back({1'b0, hi, a[7:0], 8'h00});
        model_access(a, er, es, wv, mv);
      end
    end
    m_cyc = exp_q.size();
    last_operand = m_op;
  endtask

  // Called at a falling edge with the DUT idle or in its done cycle.
  task automatic run_txn(input logic [2:0] m, input logic r, input logic s,
                         input logic [15:0] p, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] wv, input logic [7:0] mv,
                         output logic [15:0] a_ea, output logic [7:0] a_op,
                         output logic [1:0] a_nb, output int a_cyc);
    logic [24:0] op, ex;
    bit seen;
    int budget;
    model_txn(m, r, s, p, x, y, wv, mv);
    mode = m; rmw = r; store = s; pc = p; x_idx = x; y_idx = y;
    wr_value = wv; modify_value = mv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ack", {busy, done}, 2'b10);
    a_cyc = 0; seen = 0; budget = 0;
    while (!seen && budget < 24) begin
      if (done) begin
        seen = 1;
      end else begin
        if (busy) begin
          a_cyc++;
          op = {wr_en, address, wr_en ? wr_data : 8'h00};
          ex = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          check("bus_strobe", rd_en ^ wr_en, 1);
          check("bus_op", op, ex);
          if (wr_en) mem[address] = wr_data;
        end
        budget++;
        @(negedge clk);
      end
    end
    check("done_seen", seen, 1);
    if (seen) check("done_idle", {busy, rd_en, wr_en}, 0);
    check("bus_left", exp_q.size(), 0);
    a_ea = ea; a_op = operand; a_nb = nbytes;
  endtask

  logic [15:0] a_ea;
  logic [7:0]  a_op;
  logic [1:0]  a_nb;
  int          a_cyc;

  initial begin
    reset = 1'b1; start = 1'b0; mode = '0; rmw = 1'b0; store = 1'b0; pc = '0;
    x_idx = '0; y_idx = '0; wr_value = '0; modify_value = '0; last_operand = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'hC3; mem[16'h0013] = 8'h44; mem[16'h0200] = 8'h5A;
    mem[16'h0300] = 8'hF0; mem[16'h0400] = 8'hFF; mem[16'h0401] = 8'h12;
    mem[16'h0500] = 8'h00; mem[16'h0501] = 8'h30; mem[16'h0600] = 8'hFF;
    mem[16'h0601] = 8'h10; mem[16'h0700] = 8'hF0; mem[16'h0701] = 8'h20;
    mem[16'h0800] = 8'h10; mem[16'h1000] = 8'h56; mem[16'h10FF] = 8'h34;
    mem[16'h1100] = 8'h78; mem[16'h12FF] = 8'h66; mem[16'h1300] = 8'h77;
    mem[16'h3000] = 8'h81;

    vecs[0] = '{M_IMM,  1'b0, 1'b0, 16'h0200, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0200, 8'h5A, 2'd1, 1};
    vecs[1] = '{M_ZPX,  1'b0, 1'b0, 16'h0300, 8'h20, 8'h00, 8'h00, 8'h00, 16'h0010, 8'hC3, 2'd1, 2};
    vecs[2] = '{M_ABSX, 1'b0, 1'b0, 16'h0400, 8'h01, 8'h00, 8'h00, 8'h00, 16'h1300, 8'h77, 2'd2, 4};
    vecs[3] = '{M_ABSX, 1'b0, 1'b0, 16'h0400, 8'h00, 8'h00, 8'h00, 8'h00, 16'h12FF, 8'h66, 2'd2, 3};
    vecs[4] = '{M_ABS,  1'b1, 1'b0, 16'h0500, 8'h00, 8'h00, 8'h00, 8'h02, 16'h3000, 8'h81, 2'd2, 5};
`ifdef NMOS_IND_WRAP_EN
    vecs[5] = '{M_IND,  1'b0, 1'b0, 16'h0600, 8'h00, 8'h00, 8'h00, 8'h00, 16'h5634, 8'h81, 2'd2, 4};
`else
    vecs[5] = '{M_IND,  1'b0, 1'b0, 16'h0600, 8'h00, 8'h00, 8'h00, 8'h00, 16'h7834, 8'h81, 2'd2, 4};
`endif
    vecs[6] = '{M_ABSY, 1'b0, 1'b1, 16'h0700, 8'h00, 8'h05, 8'h99, 8'h00, 16'h20F5, 8'h81, 2'd2, 4};
    vecs[7] = '{M_ZPY,  1'b0, 1'b0, 16'h0800, 8'h00, 8'h03, 8'h00, 8'h00, 16'h0013, 8'h44, 2'd1, 2};

    repeat (3) @(negedge clk);
    check("rst_address", address, 0);
    check("rst_strobes", {rd_en, wr_en, busy, done}, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_ea", ea, 0);
    check("rst_operand", operand, 0);
    check("rst_nbytes", nbytes, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].mode, vecs[i].rmw, vecs[i].store, vecs[i].pc, vecs[i].x, vecs[i].y,
              vecs[i].wv, vecs[i].mv, a_ea, a_op, a_nb, a_cyc);
      check($sformatf("vec%0d_ea", i), a_ea, vecs[i].ea);
      check($sformatf("vec%0d_operand", i), a_op, vecs[i].operand);
      check($sformatf("vec%0d_nbytes", i), a_nb, vecs[i].nb);
      check($sformatf("vec%0d_cycles", i), a_cyc, vecs[i].cyc);
    end
    check("rmw_mem", mem[16'h3000], 8'h02);
    check("store_mem", mem[16'h20F5], 8'h99);

    // Reset asserted during MODIFY must kill the pending write at once.
    mem[16'h3000] = 8'h81;
    mode = M_ABS; rmw = 1'b1; store = 1'b0; pc = 16'h0500; modify_value = 8'h02;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("modify_wr", {wr_en, wr_data}, {1'b1, 8'h81});
    reset = 1'b1;
    #1;
    check("abort_strobes", {rd_en, wr_en, busy, done}, 0);
    check("abort_address", address, 0);
    @(negedge clk);
    reset = 1'b0;
    last_operand = '0;
    check("abort_mem", mem[16'h3000], 8'h81);
    run_txn(M_ZP, 1'b0, 1'b0, 16'h0800, 8'h00, 8'h00, 8'h00, 8'h00, a_ea, a_op, a_nb, a_cyc);
    check("post_rst_ea", a_ea, 16'h0010);
    check("post_rst_operand", a_op, 8'hC3);
    check("post_rst_cycles", a_cyc, 2);

    for (int i = 0; i < 60; i++) begin
      run_txn(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
              16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              a_ea, a_op, a_nb, a_cyc);
      check("rand_ea", a_ea, m_ea);
      check("rand_operand", a_op, m_op);
      check("rand_nbytes", a_nb, m_nb);
      check("rand_cycles", a_cyc, m_cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
